paddsb_seq: RTL and testbench



---
 rtl/paddsb_seq_pkg.sv | 16 +
 rtl/paddsb_seq_sat_add4.sv | 25 ++
 rtl/paddsb_seq.sv | 115 +++++++++++
 tb/tb_paddsb_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddsb_seq_pkg.sv
// Shared types and constants for the packed saturating sub-word add sequencer.
package paddsb_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int LANE_W  = 4;
   localparam int N_LANES = 4;

   localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
   localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

endpackage

// File: rtl/paddsb_seq_sat_add4.sv
// Combinational 4-bit two's-complement saturating adder; one shared lane.
module sat_add4
   import paddsb_seq_pkg::*;
(
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   output logic [LANE_W-1:0] s,
   output logic              ovf
);

   logic [LANE_W-1:0] raw;

   // Overflow only when operand signs agree and the wrapped sum flips sign;
   // the clamp direction follows the operand sign.
   always_comb begin
      raw = a + b;
      ovf = (a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
      if (ovf) begin
         s = a[LANE_W-1] ? SAT_NEG : SAT_POS;
      end else begin
         s = raw;
      end
   end

endmodule

// File: rtl/paddsb_seq.sv
// Multi-cycle PADDSB sequencer: one saturating adder stepped over four nibbles.
//
// state | meaning
// IDLE  | waiting for start; results from last operation held
// RUN   | one lane computed per cycle, lane 0 first
// DONE  | done pulse; results final; start here begins the next operation
module paddsb_seq
   import paddsb_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        busy,
   output logic        done,
   output logic [15:0] Sum,
   output logic [3:0]  sat
);

   state_e      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [15:0] sum_q, sum_d;
   logic [3:0]  sat_q, sat_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [3:0]        lane_lsb;
   logic [LANE_W-1:0] lane_a, lane_b, lane_s;
   logic              lane_ovf;

   // Lane mux feeding the single shared adder from the latched operands.
   assign lane_lsb = {lane_q, 2'b00};
   assign lane_a   = a_q[lane_lsb +: LANE_W];
   assign lane_b   = b_q[lane_lsb +: LANE_W];

   sat_add4 u_sat_add4 (
      .a   (lane_a),
      .b   (lane_b),
      .s   (lane_s),
      .ovf (lane_ovf)
   );

   // Next-state, operand capture and per-lane result write-enable decode.
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      sat_d   = sat_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
            if (start) begin
               a_d     = A;
               b_d     = B;
               sum_d   = '0;
               sat_d   = '0;
               lane_d  = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[lane_lsb +: LANE_W] = lane_s;
            sat_d[lane_q]             = lane_ovf;
            lane_d                    = lane_q + 2'd1;
            if (lane_q == 2'(N_LANES - 1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State, lane counter, operand latches and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lane_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         sat_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         sat_q   <= sat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Sum  = sum_q;
   assign sat  = sat_q;

endmodule

// File: tb/tb_paddsb_seq.sv
// Directed self-checking bench for paddsb_seq.
module tb_paddsb_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [15:0] Sum;
   logic [3:0]  sat;

   int errors;
   int checks;

   paddsb_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Sum   (Sum),
      .sat   (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   // Reset values, then release with start on the same cycle.
   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      A     = 16'h0;
      B     = 16'h0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, Sum, sat} !== 22'h0) begin
         errors++;
         $display("FAIL reset_values: got busy=%b done=%b Sum=%h sat=%h want all 0", busy, done, Sum, sat);
      end
      rst_n = 1'b1;
      start = 1'b1;
      A     = 16'h1234;
      B     = 16'h1111;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL first_start_accept: got busy=%b want 1", busy);
      end
      repeat (5) @(negedge clk);
   endtask

   // Non-saturating add with exact cycle-by-cycle busy/done timing.
   task automatic test_no_overflow();
      @(negedge clk);
      start = 1'b1;
      A     = 16'h1234;
      B     = 16'h1111;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL no_ovf_busy_c%0d: got busy=%b done=%b want busy=1 done=0", c, busy, done);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || Sum !== 16'h2345 || sat !== 4'h0) begin
         errors++;
         $display("FAIL no_ovf_done: got done=%b busy=%b Sum=%h sat=%h want done=1 busy=0 Sum=2345 sat=0", done, busy, Sum, sat);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || Sum !== 16'h2345 || sat !== 4'h0) begin
         errors++;
         $display("FAIL no_ovf_hold: got done=%b Sum=%h sat=%h want done=0 Sum=2345 sat=0", done, Sum, sat);
      end
   endtask

   // Saturation vectors: mixed lanes, all positive, all negative.
   task automatic test_saturation();
      logic [15:0] va   [3];
      logic [15:0] vb   [3];
      logic [15:0] vsum [3];
      logic [3:0]  vsat [3];
      va[0] = 16'h7F80; vb[0] = 16'h1F8F; vsum[0] = 16'h7E8F; vsat[0] = 4'b1010;
      va[1] = 16'h7777; vb[1] = 16'h1111; vsum[1] = 16'h7777; vsat[1] = 4'hF;
      va[2] = 16'h8888; vb[2] = 16'h8888; vsum[2] = 16'h8888; vsat[2] = 4'hF;
      for (int i = 0; i < 3; i++) begin
         int waited;
         @(negedge clk);
         start = 1'b1;
         A     = va[i];
         B     = vb[i];
         @(negedge clk);
         start  = 1'b0;
         waited = 1;
         while (done !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
         end
         checks++;
         if (done !== 1'b1 || waited != 5) begin
            errors++;
            $display("FAIL sat_latency_%0d: got done=%b at cycle %0d want done=1 at cycle 5", i, done, waited);
         end
         checks++;
         if (Sum !== vsum[i] || sat !== vsat[i]) begin
            errors++;
            $display("FAIL sat_result_%0d: got Sum=%h sat=%b want Sum=%h sat=%b", i, Sum, sat, vsum[i], vsat[i]);
         end
         @(negedge clk);
      end
   endtask

   // start in cycle 2 with different operands must be ignored.
   task automatic test_start_while_busy();
      int n_done;
      n_done = 0;
      @(negedge clk);
      start = 1'b1;
      A     = 16'h1234;
      B     = 16'h1111;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (c == 2) begin
            start = 1'b1;
            A     = 16'hFFFF;
            B     = 16'hFFFF;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            n_done++;
            checks++;
            if (c != 5 || Sum !== 16'h2345 || sat !== 4'h0) begin
               errors++;
               $display("FAIL busy_start_result: got done at cycle %0d Sum=%h sat=%h want cycle 5 Sum=2345 sat=0", c, Sum, sat);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (n_done != 1) begin
         errors++;
         $display("FAIL busy_start_done_count: got %0d want 1", n_done);
      end
   endtask

   // start held high: done every fifth cycle, Sum cleared on each re-accept.
   task automatic test_back_to_back();
      @(negedge clk);
      start = 1'b1;
      A     = 16'h7F80;
      B     = 16'h1F8F;
      @(negedge clk);
      for (int c = 1; c <= 15; c++) begin
         checks++;
         if (done !== (c % 5 == 0)) begin
            errors++;
            $display("FAIL b2b_done_c%0d: got %b want %b", c, done, (c % 5 == 0));
         end
         if (c % 5 == 0) begin
            checks++;
            if (Sum !== 16'h7E8F || sat !== 4'b1010) begin
               errors++;
               $display("FAIL b2b_result_c%0d: got Sum=%h sat=%b want Sum=7e8f sat=1010", c, Sum, sat);
            end
         end
         if (c == 6 || c == 11) begin
            checks++;
            if (Sum !== 16'h0000 || sat !== 4'h0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL b2b_clear_c%0d: got Sum=%h sat=%h busy=%b want Sum=0000 sat=0 busy=1", c, Sum, sat, busy);
            end
         end
         if (c == 15) start = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stop: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   // Reset asserted in cycle 3 aborts; a fresh start afterwards completes.
   task automatic test_reset_mid_op();
      int waited;
      int n_done;
      @(negedge clk);
      start = 1'b1;
      A     = 16'h7F80;
      B     = 16'h1F8F;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, Sum, sat} !== 22'h0) begin
         errors++;
         $display("FAIL mid_reset_clear: got busy=%b done=%b Sum=%h sat=%h want all 0", busy, done, Sum, sat);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      n_done = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) n_done++;
      end
      checks++;
      if (n_done != 0) begin
         errors++;
         $display("FAIL mid_reset_no_done: got %0d active cycles want 0", n_done);
      end
      start = 1'b1;
      A     = 16'h8888;
      B     = 16'h8888;
      @(negedge clk);
      start  = 1'b0;
      waited = 1;
      while (done !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (done !== 1'b1 || waited != 5 || Sum !== 16'h8888 || sat !== 4'hF) begin
         errors++;
         $display("FAIL post_reset_op: got done=%b cycle=%0d Sum=%h sat=%h want done=1 cycle=5 Sum=8888 sat=f", done, waited, Sum, sat);
      end
      @(negedge clk);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_no_overflow();
      test_saturation();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
